// File: rtl/mem_data_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : mem_data_buffer
//  Purpose  : Bidirectional staging buffer between host request logic and the
//             memory controller. Two independent first-word-fall-through
//             synchronous FIFOs (write path host->memory, read path
//             memory->host), each with valid/ready handshakes on both faces,
//             occupancy level, almost-full / almost-empty flags and a
//             synchronous flush.
//  Ports    : sys_clk, sys_rst_n (sync, active-low), flush
//             wr_in_*  / wr_out_*  : write path handshakes and data
//             rd_in_*  / rd_out_*  : read path handshakes and data
//             wr_level, rd_level   : occupancy 0..DEPTH
//             wr_afull, rd_afull, wr_aempty, rd_aempty : level flags
//             wr_stall_cnt, rd_stall_cnt : present only with
//             MDB_STALL_STATS_EN defined; saturating 16-bit counts of cycles
//             with in_valid high while in_ready is low.
//  Options  : `define MDB_STALL_STATS_EN to add the stall counters.
//  Revision : 1.0 - initial parametrised release
// ============================================================================

// ----------------------------------------------------------------------------
//  mdb_fifo : one FWFT FIFO path. All status outputs decode the registered
//  level, so no output depends combinationally on any input.
// ----------------------------------------------------------------------------
module mdb_fifo #(
  parameter int DATA_W     = 64,
  parameter int DEPTH      = 8,
  parameter int AFULL_LVL  = DEPTH - 2,
  parameter int AEMPTY_LVL = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       afull,
  output logic                       aempty
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] c_DEPTH      = LW'(DEPTH);
  localparam logic [LW-1:0] c_AFULL_LVL  = LW'(AFULL_LVL);
  localparam logic [LW-1:0] c_AEMPTY_LVL = LW'(AEMPTY_LVL);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [LW-1:0]     r_level;

  logic w_push;
  logic w_pop;

  assign in_ready  = (r_level != c_DEPTH);
  assign out_valid = (r_level != '0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  // Head is forced to zero when empty so stale storage never leaks out.
  assign out_data = out_valid ? r_mem[r_rd_ptr] : '0;
  assign level    = r_level;
  assign afull    = (r_level >= c_AFULL_LVL);
  assign aempty   = (r_level <= c_AEMPTY_LVL);

  // Storage is deliberately not reset; a flushed push is not written.
  always_ff @(posedge clk) begin
    if (w_push && rst_n && !flush) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// ----------------------------------------------------------------------------
//  mem_data_buffer : top level, two mdb_fifo instances plus optional stats.
// ----------------------------------------------------------------------------
module mem_data_buffer #(
  parameter int DATA_W     = 64,
  parameter int DEPTH      = 8,
  parameter int AFULL_LVL  = DEPTH - 2,
  parameter int AEMPTY_LVL = 1
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   flush,
  input  logic                   wr_in_valid,
  output logic                   wr_in_ready,
  input  logic [DATA_W-1:0]      wr_in_data,
  output logic                   wr_out_valid,
  input  logic                   wr_out_ready,
  output logic [DATA_W-1:0]      wr_out_data,
  input  logic                   rd_in_valid,
  output logic                   rd_in_ready,
  input  logic [DATA_W-1:0]      rd_in_data,
  output logic                   rd_out_valid,
  input  logic                   rd_out_ready,
  output logic [DATA_W-1:0]      rd_out_data,
  output logic [$clog2(DEPTH):0] wr_level,
  output logic [$clog2(DEPTH):0] rd_level,
  output logic                   wr_afull,
  output logic                   rd_afull,
  output logic                   wr_aempty,
`ifdef MDB_STALL_STATS_EN
  output logic                   rd_aempty,
  output logic [15:0]            wr_stall_cnt,
  output logic [15:0]            rd_stall_cnt
`else
  output logic                   rd_aempty
`endif
);

  mdb_fifo #(
    .DATA_W     (DATA_W),
    .DEPTH      (DEPTH),
    .AFULL_LVL  (AFULL_LVL),
    .AEMPTY_LVL (AEMPTY_LVL)
  ) u_wr_fifo (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .flush     (flush),
    .in_valid  (wr_in_valid),
    .in_ready  (wr_in_ready),
    .in_data   (wr_in_data),
    .out_valid (wr_out_valid),
    .out_ready (wr_out_ready),
    .out_data  (wr_out_data),
    .level     (wr_level),
    .afull     (wr_afull),
    .aempty    (wr_aempty)
  );

  mdb_fifo #(
    .DATA_W     (DATA_W),
    .DEPTH      (DEPTH),
    .AFULL_LVL  (AFULL_LVL),
    .AEMPTY_LVL (AEMPTY_LVL)
  ) u_rd_fifo (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .flush     (flush),
    .in_valid  (rd_in_valid),
    .in_ready  (rd_in_ready),
    .in_data   (rd_in_data),
    .out_valid (rd_out_valid),
    .out_ready (rd_out_ready),
    .out_data  (rd_out_data),
    .level     (rd_level),
    .afull     (rd_afull),
    .aempty    (rd_aempty)
  );

`ifdef MDB_STALL_STATS_EN
  logic [15:0] r_wr_stall_cnt;
  logic [15:0] r_rd_stall_cnt;

  // Stall counters survive flush; only reset clears them. They saturate.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_wr_stall_cnt <= '0;
      r_rd_stall_cnt <= '0;
    end else begin
      if (wr_in_valid && !wr_in_ready && (r_wr_stall_cnt != 16'hFFFF))
        r_wr_stall_cnt <= r_wr_stall_cnt + 16'd1;
      if (rd_in_valid && !rd_in_ready && (r_rd_stall_cnt != 16'hFFFF))
        r_rd_stall_cnt <= r_rd_stall_cnt + 16'd1;
    end
  end

  assign wr_stall_cnt = r_wr_stall_cnt;
  assign rd_stall_cnt = r_rd_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_data_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_data_buffer
//  Purpose  : Directed self-checking bench for mem_data_buffer
//             (DATA_W = 64, DEPTH = 8). Stall-counter checks are compiled in
//             when MDB_STALL_STATS_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_data_buffer;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 8;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n;
  logic              flush;
  logic              wr_in_valid;
  logic              wr_in_ready;
  logic [DATA_W-1:0] wr_in_data;
  logic              wr_out_valid;
  logic              wr_out_ready;
  logic [DATA_W-1:0] wr_out_data;
  logic              rd_in_valid;
  logic              rd_in_ready;
  logic [DATA_W-1:0] rd_in_data;
  logic              rd_out_valid;
  logic              rd_out_ready;
  logic [DATA_W-1:0] rd_out_data;
  logic [3:0]        wr_level;
  logic [3:0]        rd_level;
  logic              wr_afull;
  logic              rd_afull;
  logic              wr_aempty;
  logic              rd_aempty;
`ifdef MDB_STALL_STATS_EN
  logic [15:0]       wr_stall_cnt;
  logic [15:0]       rd_stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 sys_clk = ~sys_clk;

  mem_data_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .flush        (flush),
    .wr_in_valid  (wr_in_valid),
    .wr_in_ready  (wr_in_ready),
    .wr_in_data   (wr_in_data),
    .wr_out_valid (wr_out_valid),
    .wr_out_ready (wr_out_ready),
    .wr_out_data  (wr_out_data),
    .rd_in_valid  (rd_in_valid),
    .rd_in_ready  (rd_in_ready),
    .rd_in_data   (rd_in_data),
    .rd_out_valid (rd_out_valid),
    .rd_out_ready (rd_out_ready),
    .rd_out_data  (rd_out_data),
    .wr_level     (wr_level),
    .rd_level     (rd_level),
    .wr_afull     (wr_afull),
    .rd_afull     (rd_afull),
    .wr_aempty    (wr_aempty),
`ifdef MDB_STALL_STATS_EN
    .rd_aempty    (rd_aempty),
    .wr_stall_cnt (wr_stall_cnt),
    .rd_stall_cnt (rd_stall_cnt)
`else
    .rd_aempty    (rd_aempty)
`endif
  );

  // Advance one clock; outputs are observed 1 time unit after the edge.
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0; flush = 1'b0;
    wr_in_valid = 1'b0; wr_in_data = '0; wr_out_ready = 1'b0;
    rd_in_valid = 1'b0; rd_in_data = '0; rd_out_ready = 1'b0;
    tick(); tick();
    sys_rst_n = 1'b1;
    total++;
    if ({wr_level, rd_level} !== 8'h00) begin
      bad++; $display("FAIL reset_level: got wr=%0d rd=%0d want 0 0", wr_level, rd_level);
    end
    total++;
    if ({wr_out_valid, rd_out_valid, wr_in_ready, rd_in_ready} !== 4'b0011) begin
      bad++; $display("FAIL reset_hs: got ov=%b%b ir=%b%b want 00 11",
                      wr_out_valid, rd_out_valid, wr_in_ready, rd_in_ready);
    end
    total++;
    if ({wr_afull, rd_afull, wr_aempty, rd_aempty} !== 4'b0011) begin
      bad++; $display("FAIL reset_flags: got af=%b%b ae=%b%b want 00 11",
                      wr_afull, rd_afull, wr_aempty, rd_aempty);
    end
    total++;
    if (wr_out_data !== 64'h0 || rd_out_data !== 64'h0) begin
      bad++; $display("FAIL reset_data: got wr=%h rd=%h want 0 0", wr_out_data, rd_out_data);
    end
  endtask

  // Push 1..8 with no consumer: level steps, afull at 6, full after 8.
  task automatic test_fill_write();
    for (int i = 1; i <= DEPTH; i++) begin
      wr_in_valid = 1'b1;
      wr_in_data  = 64'(i);
      tick();
      total++;
      if (wr_level !== 4'(i)) begin
        bad++; $display("FAIL fill_level[%0d]: got %0d want %0d", i, wr_level, i);
      end
      total++;
      if (wr_afull !== (i >= 6) || wr_aempty !== (i <= 1)) begin
        bad++; $display("FAIL fill_flags[%0d]: got af=%b ae=%b want af=%b ae=%b",
                        i, wr_afull, wr_aempty, (i >= 6), (i <= 1));
      end
      total++;
      if (wr_out_valid !== 1'b1 || wr_out_data !== 64'h1) begin
        bad++; $display("FAIL fill_head[%0d]: got v=%b d=%h want v=1 d=1", i, wr_out_valid, wr_out_data);
      end
    end
    total++;
    if (wr_in_ready !== 1'b0) begin
      bad++; $display("FAIL fill_full_ready: got %b want 0", wr_in_ready);
    end
  endtask

  // Full FIFO, pop one while offering 9: 9 must wait a cycle.
  task automatic test_full_backpressure();
    wr_in_valid = 1'b1; wr_in_data = 64'h9; wr_out_ready = 1'b1;
    tick();
    wr_out_ready = 1'b0;
    total++;
    if (wr_level !== 4'd7 || wr_in_ready !== 1'b1 || wr_out_data !== 64'h2) begin
      bad++; $display("FAIL bp_pop: got lvl=%0d ir=%b d=%h want lvl=7 ir=1 d=2",
                      wr_level, wr_in_ready, wr_out_data);
    end
    tick();
    wr_in_valid = 1'b0;
    total++;
    if (wr_level !== 4'd8 || wr_in_ready !== 1'b0) begin
      bad++; $display("FAIL bp_accept: got lvl=%0d ir=%b want lvl=8 ir=0", wr_level, wr_in_ready);
    end
    wr_out_ready = 1'b1;
    for (int i = 2; i <= 9; i++) begin
      total++;
      if (wr_out_valid !== 1'b1 || wr_out_data !== 64'(i)) begin
        bad++; $display("FAIL bp_drain[%0d]: got v=%b d=%h want v=1 d=%h", i, wr_out_valid, wr_out_data, 64'(i));
      end
      tick();
    end
    wr_out_ready = 1'b0;
    total++;
    if (wr_level !== 4'd0 || wr_out_valid !== 1'b0) begin
      bad++; $display("FAIL bp_empty: got lvl=%0d v=%b want 0 0", wr_level, wr_out_valid);
    end
  endtask

  // Read path streaming at level 1: 21 pushes wrap the pointers twice.
  task automatic test_read_stream();
    rd_in_valid = 1'b1; rd_in_data = 64'h0;
    tick();
    for (int i = 0; i < 20; i++) begin
      rd_in_data   = 64'(i + 1);
      rd_out_ready = 1'b1;
      total++;
      if (rd_out_valid !== 1'b1 || rd_out_data !== 64'(i)) begin
        bad++; $display("FAIL stream_data[%0d]: got v=%b d=%h want v=1 d=%h", i, rd_out_valid, rd_out_data, 64'(i));
      end
      tick();
      total++;
      if (rd_level !== 4'd1) begin
        bad++; $display("FAIL stream_level[%0d]: got %0d want 1", i, rd_level);
      end
    end
    rd_in_valid = 1'b0;
    total++;
    if (rd_out_data !== 64'd20) begin
      bad++; $display("FAIL stream_last: got %h want %h", rd_out_data, 64'd20);
    end
    tick();
    rd_out_ready = 1'b0;
  endtask

  // Popping an empty FIFO must have no effect.
  task automatic test_read_empty();
    rd_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (rd_out_valid !== 1'b0 || rd_out_data !== 64'h0 || rd_level !== 4'd0) begin
        bad++; $display("FAIL empty_pop[%0d]: got v=%b d=%h lvl=%0d want 0 0 0",
                        i, rd_out_valid, rd_out_data, rd_level);
      end
    end
    rd_out_ready = 1'b0;
  endtask

  // Flush with a concurrent push and pop, then a mid-transfer reset.
  task automatic test_flush_reset();
    for (int i = 0; i < 5; i++) begin
      wr_in_valid = 1'b1; wr_in_data = 64'(16 + i);
      tick();
    end
    total++;
    if (wr_level !== 4'd5) begin
      bad++; $display("FAIL flush_pre_level: got %0d want 5", wr_level);
    end
    flush = 1'b1; wr_in_data = 64'hAA; wr_out_ready = 1'b1;
    tick();
    flush = 1'b0; wr_in_valid = 1'b0; wr_out_ready = 1'b0;
    total++;
    if (wr_level !== 4'd0 || wr_out_valid !== 1'b0 || wr_out_data !== 64'h0 ||
        wr_in_ready !== 1'b1 || wr_aempty !== 1'b1) begin
      bad++; $display("FAIL flush_state: got lvl=%0d v=%b d=%h ir=%b ae=%b want 0 0 0 1 1",
                      wr_level, wr_out_valid, wr_out_data, wr_in_ready, wr_aempty);
    end
    for (int i = 0; i < 3; i++) begin
      wr_in_valid = 1'b1; wr_in_data = 64'(85 + i);
      tick();
    end
    wr_in_valid = 1'b0;
    total++;
    if (wr_level !== 4'd3 || wr_out_data !== 64'd85) begin
      bad++; $display("FAIL flush_after: got lvl=%0d d=%h want lvl=3 d=%h", wr_level, wr_out_data, 64'd85);
    end
    sys_rst_n = 1'b0; wr_in_valid = 1'b1; wr_in_data = 64'hBB;
    tick();
    sys_rst_n = 1'b1; wr_in_valid = 1'b0;
    total++;
    if (wr_level !== 4'd0 || wr_out_valid !== 1'b0 || wr_out_data !== 64'h0 ||
        wr_in_ready !== 1'b1 || wr_afull !== 1'b0 || wr_aempty !== 1'b1) begin
      bad++; $display("FAIL reset_mid: got lvl=%0d v=%b d=%h ir=%b af=%b ae=%b want 0 0 0 1 0 1",
                      wr_level, wr_out_valid, wr_out_data, wr_in_ready, wr_afull, wr_aempty);
    end
  endtask

`ifdef MDB_STALL_STATS_EN
  // Ten blocked offers against a full write FIFO count ten stall cycles.
  task automatic test_stall_stats();
    for (int i = 0; i < DEPTH + 10; i++) begin
      wr_in_valid = 1'b1; wr_in_data = 64'(i);
      tick();
    end
    wr_in_valid = 1'b0;
    tick();
    total++;
    if (wr_stall_cnt !== 16'd10 || rd_stall_cnt !== 16'd0) begin
      bad++; $display("FAIL stall_count: got wr=%0d rd=%0d want 10 0", wr_stall_cnt, rd_stall_cnt);
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++;
    if (wr_stall_cnt !== 16'd10) begin
      bad++; $display("FAIL stall_flush: got %0d want 10", wr_stall_cnt);
    end
    sys_rst_n = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    total++;
    if (wr_stall_cnt !== 16'd0) begin
      bad++; $display("FAIL stall_reset: got %0d want 0", wr_stall_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill_write();
    test_full_backpressure();
    test_read_stream();
    test_read_empty();
    test_flush_reset();
`ifdef MDB_STALL_STATS_EN
    test_stall_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
